lenet_conv1_pool: RTL and testbench
===================================

Name: lenet_conv1_pool

Overview:
- First feature-extraction stage of the LeNet accelerator: 5x5 convolution, ReLU, then 2x2/stride-2 max-pooling.
- Six output channels are computed in parallel.
- Input is a raster-ordered 32x32 single-channel image, one pixel per cycle.
- Output is six 14x14 pooled feature maps, fed to the layer-2 stage.

Parameters:
IMG_W, 32, input image width and height (square)
K, 5, kernel size
NCH, 6, output channels
DW, 16, data/weight width (signed Q8.8)
FRAC, 8, fractional bits

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous active-low reset
weights  input  NCH*DW  one kernel tap for all channels; channel 0 in bits [95:80], channel 5 in [15:0]
wen  input  1  weight write enable
datain  input  DW  signed Q8.8 pixel
enable  input  1  pixel valid
dout  output  NCH*DW  pooled result, channel 0 in MSBs
layer1_out  output  NCH  per-channel pooled-output valid pulse, channel 0 = bit 5
layer1_finish  output  NCH  per-channel sticky frame-done, channel 0 = bit 5

Behaviour:
Interface:
- One clock; reset is synchronous and active-low.
- Reset (reset==0 at a rising edge) clears:
  - dout=0, layer1_out=0, layer1_finish=0
  - pixel row/col counters, tap counter, line buffers, pool buffers
- Weights are not cleared by reset.

Weight load:
- When wen=1, weights are written to tap index k (0..24, row-major, k=ky*5+kx) of all channels.
- k increments each write and wraps 24->0.
- k resets to 0 on reset.

Pixel accept and counters:
- A pixel is accepted when enable=1, wen=0, and layer1_finish==0.
- If wen=1, datain is ignored that cycle (wen has priority).
- Row/col counters advance per accepted pixel, col 0..31 then row++.

Windowing and convolution:
- 4 line buffers of IMG_W entries plus a 5x5 window register.
- A conv window is complete when the accepted pixel has row>=4 and col>=4.
- Conv output coordinate is (row-4, col-4), range 0..27.
- Arithmetic per channel: sum of 25 signed 16x16 products in 38-bit accumulation.
- Result = sum >>> FRAC, saturated to [-32768, 32767], then ReLU (negative -> 0).
- Conv result is registered 1 cycle after the completing pixel.

Pooling:
- 2x2 max over conv outputs (2p..2p+1, 2q..2q+1), p,q in 0..13.
- Even-row conv partial maxima are held in a 14-entry buffer per channel.
- On an odd conv row and odd conv column, the pooled max is registered into dout with layer1_out=all ones for exactly 1 cycle.
- Latency: 2 cycles after the accepted pixel that completes the 2x2 group.
- dout holds its value between pulses.

Frame completion:
- Raster order of outputs is q fastest, then p; 196 outputs per frame.
- layer1_finish is set to all ones in the same cycle as the 196th layer1_out pulse and stays high.
- While finish is high, further pixels are ignored.
- Only reset starts a new frame.

Reset mid-frame:
- Aborts the frame; the next accepted pixel is (0,0).
- Loaded weights are retained.

Bubbles:
- enable=0 gaps stall the pipeline counters.
- Registered results still emerge at their fixed latency relative to the completing pixel.

Test Plan:
1. Reset: hold reset=0 3 cycles with random inputs -> dout=0, layer1_out=0, layer1_finish=0.
2. Identity kernel: wen 25 cycles, tap 12=0x0100 for all channels, others 0; stream pixel (r,c) raw value r*32+c.
   - First pooled output on all channels = 99; last = 957.
   - Exactly 196 pulses.
   - First pulse 2 cycles after pixel (5,5) is accepted.
3. Finish: after test 2, layer1_finish=6'b111111 in the same cycle as pulse 196.
   - 100 extra pixels -> no pulses, dout unchanged.
4. ReLU/saturation:
   - Weights all 0x0100, pixels all 0xFF00 -> all outputs 0.
   - Weights and pixels all 0x7FFF -> all outputs 0x7FFF.
5. Channel ordering: channel n tap 12 = (n+1)*0x0100, identity image -> channel n output = (n+1)*99 at first pulse, channel 0 in dout[95:80].
6. wen priority / mid-frame reset:
   - enable=1 with wen=1 for 25 cycles -> no pixel accepted (first pulse timing unchanged when streaming resumes).
   - reset after 300 pixels, then restream -> pulse sequence restarts at 99.

Source files
------------

// File: rtl/lenet_conv1_pool_if.sv
// lenet_conv1_pool_if: pixel/weight input bundle and pooled-result output bundle of conv1.
// master drives weights/wen/datain/enable and observes dout/layer1_out/layer1_finish;
// slave is the conv1 stage itself. Multi-channel buses carry channel 0 in the top lane.
interface lenet_conv1_pool_if #(
  parameter int NCH = 6,
  parameter int DW  = 16
);
  logic [NCH*DW-1:0] weights;
  logic              wen;
  logic [DW-1:0]     datain;
  logic              enable;
  logic [NCH*DW-1:0] dout;
  logic [NCH-1:0]    layer1_out;
  logic [NCH-1:0]    layer1_finish;

  modport master (
    output weights, wen, datain, enable,
    input  dout, layer1_out, layer1_finish
  );

  modport slave (
    input  weights, wen, datain, enable,
    output dout, layer1_out, layer1_finish
  );
endinterface

// File: rtl/lenet_conv1_pool.sv
// lenet_conv1_pool: 5x5 conv (6 parallel channels, Q8.8) + ReLU + 2x2/2 max-pool of a raster image.
// Latency: pooled result and layer1_out pulse 2 cycles after the pixel completing its 2x2 group.
// Backpressure: none; a pixel is taken on enable && !wen && !finish, enable=0 gaps stall counters.
// Ports: clk; reset (synchronous, active-low); bus (slave) carries weights/wen/datain/enable in
//        and dout/layer1_out/layer1_finish out.
module lenet_conv1_pool #(
  parameter int IMG_W = 32,
  parameter int K     = 5,
  parameter int NCH   = 6,
  parameter int DW    = 16,
  parameter int FRAC  = 8
) (
  input  logic              clk,
  input  logic              reset,
  lenet_conv1_pool_if.slave bus
);
  localparam int AW   = 38;
  localparam int NTAP = K * K;
  localparam int TW   = $clog2(NTAP);
  localparam int CW   = $clog2(IMG_W);
  localparam int PW   = (IMG_W - K + 1) / 2;
  localparam int NOUT = PW * PW;
  localparam int NW   = $clog2(NOUT + 1);

  typedef logic signed [DW-1:0] pix_t;

  localparam logic [TW-1:0]        LAST_TAP = TW'(NTAP - 1);
  localparam logic [CW-1:0]        LAST_COL = CW'(IMG_W - 1);
  localparam logic [CW-1:0]        WIN_MIN  = CW'(K - 1);
  localparam logic [NW-1:0]        LAST_OUT = NW'(NOUT - 1);
  localparam logic signed [AW-1:0] SAT_MAX  = AW'((1 << (DW - 1)) - 1);

  function automatic pix_t vmax(pix_t a, pix_t b);
    return (a > b) ? a : b;
  endfunction

  // Weights survive reset: they are loaded once and reused across frames.
  pix_t wgt_q [NCH][NTAP];

  logic [TW-1:0] tap_q, tap_d;
  logic [CW-1:0] row_q, row_d, col_q, col_d;
  pix_t          lbuf_q [K-1][IMG_W];   // lbuf_q[0] is the previous row, lbuf_q[K-2] the oldest
  pix_t          win_q  [K][K];         // win_q[ky][kx] = pixel (row-4+ky, col-4+kx)
  logic          win_vld_q, win_rodd_q;
  logic [CW-1:0] win_c_q;

  logic signed [AW-1:0] acc [NCH];
  logic signed [AW-1:0] shv [NCH];
  pix_t                 conv_d [NCH];
  pix_t                 conv_q [NCH];
  logic                 conv_vld_q, conv_rodd_q;
  logic [CW-1:0]        conv_c_q;

  pix_t          hmax_q [NCH];          // max of the even/odd column pair on the current conv row
  pix_t          pbuf_q [NCH][PW];      // even-row pair maxima awaiting the odd row
  pix_t          dout_q [NCH];
  logic          pulse_q, fin_q;
  logic [NW-1:0] cnt_q;

  logic accept;
  pix_t pix;
  assign accept = bus.enable && !bus.wen && !fin_q;
  assign pix    = bus.datain;

  always_comb begin
    tap_d = tap_q;
    row_d = row_q;
    col_d = col_q;
    if (bus.wen) tap_d = (tap_q == LAST_TAP) ? '0 : tap_q + 1'b1;
    if (accept) begin
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && bus.wen) begin
      for (int c = 0; c < NCH; c++) wgt_q[c][tap_q] <= bus.weights[(NCH-1-c)*DW +: DW];
    end
  end

  // Convolution: full-precision accumulate, scale back to Q8.8, clamp, then ReLU.
  // A negative sum clamps to -32768 and ReLU maps it to 0, so both collapse to "<= 0 -> 0".
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      acc[c] = '0;
      for (int ky = 0; ky < K; ky++) begin
        for (int kx = 0; kx < K; kx++) begin
          acc[c] = acc[c] + AW'(win_q[ky][kx]) * AW'(wgt_q[c][ky*K+kx]);
        end
      end
      shv[c] = acc[c] >>> FRAC;
      if (shv[c][AW-1] || shv[c] == '0) conv_d[c] = '0;
      else if (shv[c] > SAT_MAX)        conv_d[c] = pix_t'(SAT_MAX[DW-1:0]);
      else                              conv_d[c] = shv[c][DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tap_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      win_vld_q   <= 1'b0;
      win_rodd_q  <= 1'b0;
      win_c_q     <= '0;
      conv_vld_q  <= 1'b0;
      conv_rodd_q <= 1'b0;
      conv_c_q    <= '0;
      pulse_q     <= 1'b0;
      fin_q       <= 1'b0;
      cnt_q       <= '0;
      for (int i = 0; i < K-1; i++) for (int x = 0; x < IMG_W; x++) lbuf_q[i][x] <= '0;
      for (int ky = 0; ky < K; ky++) for (int kx = 0; kx < K; kx++) win_q[ky][kx] <= '0;
      for (int c = 0; c < NCH; c++) begin
        conv_q[c] <= '0;
        hmax_q[c] <= '0;
        dout_q[c] <= '0;
        for (int p = 0; p < PW; p++) pbuf_q[c][p] <= '0;
      end
    end else begin
      tap_q <= tap_d;
      row_q <= row_d;
      col_q <= col_d;

      // Stage 1: shift the window one column left and bring in the new column.
      if (accept) begin
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K-1; kx++) win_q[ky][kx] <= win_q[ky][kx+1];
        for (int ky = 0; ky < K-1; ky++) win_q[ky][K-1] <= lbuf_q[K-2-ky][col_q];
        win_q[K-1][K-1] <= pix;
        lbuf_q[0][col_q] <= pix;
        for (int i = 1; i < K-1; i++) lbuf_q[i][col_q] <= lbuf_q[i-1][col_q];
      end
      win_vld_q  <= accept && (row_q >= WIN_MIN) && (col_q >= WIN_MIN);
      win_rodd_q <= row_q[0] ^ WIN_MIN[0];
      win_c_q    <= col_q - WIN_MIN;

      // Stage 2: register the conv result with its coordinate.
      conv_vld_q  <= win_vld_q;
      conv_rodd_q <= win_rodd_q;
      conv_c_q    <= win_c_q;
      for (int c = 0; c < NCH; c++) conv_q[c] <= conv_d[c];

      // Stage 3: pooling; the odd-row/odd-column conv output closes a 2x2 group.
      pulse_q <= 1'b0;
      if (conv_vld_q) begin
        for (int c = 0; c < NCH; c++) begin
          if (!conv_c_q[0])
            hmax_q[c] <= conv_q[c];
          else if (!conv_rodd_q)
            pbuf_q[c][conv_c_q[CW-1:1]] <= vmax(hmax_q[c], conv_q[c]);
          else
            dout_q[c] <= vmax(pbuf_q[c][conv_c_q[CW-1:1]], vmax(hmax_q[c], conv_q[c]));
        end
        if (conv_rodd_q && conv_c_q[0]) begin
          pulse_q <= 1'b1;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST_OUT) fin_q <= 1'b1;
        end
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_dout
    assign bus.dout[(NCH-1-c)*DW +: DW] = dout_q[c];
  end
  assign bus.layer1_out    = {NCH{pulse_q}};
  assign bus.layer1_finish = {NCH{fin_q}};
endmodule

// File: tb/tb_lenet_conv1_pool.sv
// tb_lenet_conv1_pool: directed frames against a behavioural conv/ReLU/pool model plus literal pins.
// Latency: expects each pooled pulse exactly 2 cycles after the pixel completing its 2x2 group.
// Backpressure: none; the bench inserts enable=0 bubbles and wen-priority cycles.
module tb_lenet_conv1_pool;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lenet_conv1_pool_if bus ();
  lenet_conv1_pool dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  int          img [32][32];
  int          w   [6][25];
  logic [15:0] wset [6][25];
  int          mrow, mcol, mtap;
  bit          mdone;
  logic [95:0] exp_q [$];
  int          exp_cyc [$];
  logic [95:0] dout_m;
  int          fin_cyc;
  int          cyc = 0;
  bit          chk_en = 1'b0;

  // Observations for the literal checks
  int          npulse, first_pulse_cyc, pix55_cyc;
  logic [95:0] first_dout, last_dout;
  logic [5:0]  fin_at_last;

  function automatic logic [15:0] conv_m(int ch, int cr, int cc);
    longint s = 0;
    longint sh;
    for (int ky = 0; ky < 5; ky++)
      for (int kx = 0; kx < 5; kx++)
        s += longint'(img[cr+ky][cc+kx]) * longint'(w[ch][ky*5+kx]);
    sh = s >>> 8;
    if (sh <= 0) return 16'd0;
    if (sh > 32767) return 16'h7FFF;
    return 16'(sh);
  endfunction

  function automatic logic [95:0] pool_m(int p, int q);
    logic [95:0] r = '0;
    for (int ch = 0; ch < 6; ch++) begin
      logic [15:0] m = 16'd0;
      for (int dy = 0; dy < 2; dy++)
        for (int dx = 0; dx < 2; dx++)
          if (conv_m(ch, 2*p+dy, 2*q+dx) > m) m = conv_m(ch, 2*p+dy, 2*q+dx);
      r[(5-ch)*16 +: 16] = m;
    end
    return r;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    exp_cyc.delete();
    dout_m = '0;
    fin_cyc = -1;
    mrow = 0; mcol = 0; mtap = 0; mdone = 1'b0;
    npulse = 0; first_pulse_cyc = -1; pix55_cyc = -100;
    first_dout = '0; last_dout = '0; fin_at_last = '0;
  endtask

  task automatic lit(input string nm, input logic [95:0] got, input logic [95:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // Per-cycle compare: pulse timing, dout value/hold, finish flag.
  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_p;
      bit exp_f;
      while (exp_cyc.size() > 0 && exp_cyc[0] < cyc) begin
        void'(exp_cyc.pop_front());
        void'(exp_q.pop_front());
      end
      exp_p = (exp_cyc.size() > 0 && exp_cyc[0] == cyc);
      if (exp_p) begin
        dout_m = exp_q.pop_front();
        void'(exp_cyc.pop_front());
      end
      exp_f = (fin_cyc >= 0 && cyc >= fin_cyc);
      checks++;
      if (bus.layer1_out !== (exp_p ? 6'h3F : 6'h00)) begin
        failures++;
        $display("FAIL pulse cyc=%0d got=%b want=%b", cyc, bus.layer1_out, exp_p ? 6'h3F : 6'h00);
      end
      checks++;
      if (bus.dout !== dout_m) begin
        failures++;
        $display("FAIL dout cyc=%0d got=%h want=%h", cyc, bus.dout, dout_m);
      end
      checks++;
      if (bus.layer1_finish !== (exp_f ? 6'h3F : 6'h00)) begin
        failures++;
        $display("FAIL finish cyc=%0d got=%b want=%b", cyc, bus.layer1_finish, exp_f ? 6'h3F : 6'h00);
      end
      if (bus.layer1_out !== 6'h00) begin
        npulse++;
        if (npulse == 1) begin
          first_dout = bus.dout;
          first_pulse_cyc = cyc;
        end
        last_dout = bus.dout;
        if (npulse == 196) fin_at_last = bus.layer1_finish;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.enable = 1'b0;
      bus.wen = 1'b0;
      bus.datain = 16'($urandom);
      step();
    end
  endtask

  task automatic send_pix(input logic [15:0] v);
    bus.enable = 1'b1;
    bus.wen = 1'b0;
    bus.datain = v;
    step();
    if (!mdone) begin
      img[mrow][mcol] = int'($signed(v));
      if (mrow == 5 && mcol == 5) pix55_cyc = cyc;
      if (mrow >= 5 && mcol >= 5 && (mrow % 2) == 1 && (mcol % 2) == 1) begin
        exp_q.push_back(pool_m((mrow-5)/2, (mcol-5)/2));
        exp_cyc.push_back(cyc + 2);
        if (mrow == 31 && mcol == 31) fin_cyc = cyc + 2;
      end
      if (mcol == 31) begin
        mcol = 0;
        if (mrow == 31) mdone = 1'b1;
        else mrow++;
      end else begin
        mcol++;
      end
    end
    bus.enable = 1'b0;
  endtask

  task automatic load_w(input bit with_en);
    for (int k = 0; k < 25; k++) begin
      for (int ch = 0; ch < 6; ch++) bus.weights[(5-ch)*16 +: 16] = wset[ch][k];
      bus.wen = 1'b1;
      bus.enable = with_en;
      bus.datain = 16'($urandom);
      step();
      for (int ch = 0; ch < 6; ch++) w[ch][mtap] = int'($signed(wset[ch][k]));
      mtap = (mtap + 1) % 25;
    end
    bus.wen = 1'b0;
    bus.enable = 1'b0;
  endtask

  task automatic set_w(input int mode);
    for (int ch = 0; ch < 6; ch++)
      for (int k = 0; k < 25; k++)
        case (mode)
          0: wset[ch][k] = (k == 12) ? 16'h0100 : 16'h0000;
          1: wset[ch][k] = 16'h0100;
          2: wset[ch][k] = 16'h7FFF;
          default: wset[ch][k] = (k == 12) ? 16'((ch + 1) * 256) : 16'h0000;
        endcase
  endtask

  task automatic stream(input int mode, input int npix, input bit bub);
    for (int i = 0; i < npix; i++) begin
      logic [15:0] v;
      if (bub && (i % 11) == 5) idle(1 + i % 3);
      case (mode)
        0: v = 16'(i);
        1: v = 16'hFF00;
        default: v = 16'h7FFF;
      endcase
      send_pix(v);
    end
  endtask

  task automatic do_reset();
    idle(4);
    reset = 1'b0;
    step();
    model_clear();
    idle(2);
    reset = 1'b1;
  endtask

  initial begin
    // 1: reset with random inputs
    for (int i = 0; i < 3; i++) begin
      bus.weights = {$urandom, $urandom, $urandom};
      bus.wen = 1'($urandom);
      bus.datain = 16'($urandom);
      bus.enable = 1'($urandom);
      step();
      lit("reset_dout", bus.dout, 96'd0);
      lit("reset_out", 96'(bus.layer1_out), 96'd0);
      lit("reset_finish", 96'(bus.layer1_finish), 96'd0);
    end
    bus.wen = 1'b0;
    bus.enable = 1'b0;
    model_clear();
    chk_en = 1'b1;
    reset = 1'b1;

    // 2: identity kernel, full frame with bubbles
    set_w(0);
    load_w(1'b0);
    stream(0, 1024, 1'b1);
    idle(4);
    lit("ident_first", first_dout, {6{16'd99}});
    lit("ident_last", last_dout, {6{16'd957}});
    lit("ident_count", 96'(npulse), 96'd196);
    lit("ident_latency", 96'(first_pulse_cyc - pix55_cyc), 96'd2);

    // 3: finish is sticky and blocks further pixels
    lit("finish_at_196", 96'(fin_at_last), 96'h3F);
    stream(0, 100, 1'b0);
    idle(4);
    lit("finish_count", 96'(npulse), 96'd196);
    lit("finish_dout_held", bus.dout, {6{16'd957}});
    lit("finish_sticky", 96'(bus.layer1_finish), 96'h3F);

    // 4: ReLU of negative sums and positive saturation
    do_reset();
    set_w(1);
    load_w(1'b0);
    stream(1, 192, 1'b0);
    idle(4);
    lit("relu_count", 96'(npulse), 96'd14);
    lit("relu_first", first_dout, 96'd0);
    do_reset();
    set_w(2);
    load_w(1'b0);
    stream(2, 192, 1'b1);
    idle(4);
    lit("sat_first", first_dout, {6{16'h7FFF}});

    // 5: per-channel gains and lane ordering
    do_reset();
    set_w(3);
    load_w(1'b0);
    stream(0, 192, 1'b0);
    idle(4);
    lit("chan_first", first_dout, {16'd99, 16'd198, 16'd297, 16'd396, 16'd495, 16'd594});

    // 6: wen priority over enable, then mid-frame reset with retained weights
    do_reset();
    set_w(0);
    load_w(1'b1);
    stream(0, 300, 1'b0);
    idle(4);
    lit("wenprio_first", first_dout, {6{16'd99}});
    lit("wenprio_latency", 96'(first_pulse_cyc - pix55_cyc), 96'd2);
    do_reset();
    stream(0, 1024, 1'b1);
    idle(4);
    lit("restart_first", first_dout, {6{16'd99}});
    lit("restart_last", last_dout, {6{16'd957}});
    lit("restart_count", 96'(npulse), 96'd196);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
